// File: rtl/sync_r2w_flags.sv
// Read-to-write crossing for the dual-clock FIFO: synchronises the Gray read pointer and the
// empty flag into wr_clk_i and derives full/almost-full/used-word. Optional checker: SYNC_R2W_GRAY_CHECK_EN.
module sync_r2w_flags #(
    parameter int AWIDTH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 2**AWIDTH - 1
) (
    input  logic              wr_clk_i,
    input  logic              aclr_i,
    input  logic [AWIDTH:0]   wr_pntr_next_i,
    input  logic [AWIDTH:0]   rd_pntr_gray_wr_i,
    input  logic              rd_empty_wr_i,
    output logic [AWIDTH:0]   rd_pntr_gray_o,
    output logic [AWIDTH:0]   rd_pntr_bin_o,
    output logic              wr_empty_o,
    output logic [AWIDTH:0]   wr_usedw_o,
    output logic              wr_full_o,
    output logic              wr_almost_full_o,
    output logic              gray_err_o
);

    localparam int              PW         = AWIDTH + 1;
    localparam logic [AWIDTH:0] FULL_COUNT = PW'(2**AWIDTH);
    localparam logic [AWIDTH:0] AF_COUNT   = PW'(AF_LEVEL);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("sync_r2w_flags: SYNC_STAGES must be at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > 2**AWIDTH) begin : g_bad_af
            $error("sync_r2w_flags: AF_LEVEL must lie in 1..2**AWIDTH");
        end
    endgenerate

    logic [AWIDTH:0]        ptr_sync_reg [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] empty_sync_reg;
    logic [AWIDTH:0]        rd_bin;
    logic [AWIDTH:0]        used_next;
    logic [AWIDTH:0]        rd_bin_reg;
    logic [AWIDTH:0]        usedw_reg;
    logic                   full_reg;
    logic                   almost_full_reg;

    // Synchroniser chains; empty stages reset to 1 so the write side starts out "empty".
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge wr_clk_i or posedge aclr_i) begin
                if (aclr_i) begin
                    ptr_sync_reg[gi]   <= '0;
                    empty_sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    ptr_sync_reg[gi]   <= rd_pntr_gray_wr_i;
                    empty_sync_reg[gi] <= rd_empty_wr_i;
                end else begin
                    ptr_sync_reg[gi]   <= ptr_sync_reg[(gi == 0) ? 0 : gi-1];
                    empty_sync_reg[gi] <= empty_sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign rd_pntr_gray_o = ptr_sync_reg[SYNC_STAGES-1];
    assign wr_empty_o     = empty_sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= AWIDTH; gi++) begin : g_g2b
            assign rd_bin[gi] = ^rd_pntr_gray_o[AWIDTH:gi];
        end
    endgenerate

    // Modular difference absorbs pointer wrap; a stale read pointer only over-reports occupancy.
    assign used_next = wr_pntr_next_i - rd_bin;

    always_ff @(posedge wr_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            rd_bin_reg      <= '0;
            usedw_reg       <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
        end else begin
            rd_bin_reg      <= rd_bin;
            usedw_reg       <= used_next;
            full_reg        <= (used_next == FULL_COUNT);
            almost_full_reg <= (used_next >= AF_COUNT);
        end
    end

    assign rd_pntr_bin_o    = rd_bin_reg;
    assign wr_usedw_o       = usedw_reg;
    assign wr_full_o        = full_reg;
    assign wr_almost_full_o = almost_full_reg;

`ifdef SYNC_R2W_GRAY_CHECK_EN
    logic [AWIDTH:0] gray_prev_reg;
    logic [AWIDTH:0] gray_delta;
    logic            gray_err_reg;

    // Clearing the lowest set bit leaves a non-zero value only when two or more bits changed.
    assign gray_delta = rd_pntr_gray_o ^ gray_prev_reg;

    always_ff @(posedge wr_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            gray_prev_reg <= '0;
            gray_err_reg  <= 1'b0;
        end else begin
            gray_prev_reg <= rd_pntr_gray_o;
            gray_err_reg  <= gray_err_reg | (|(gray_delta & (gray_delta - PW'(1))));
        end
    end

    assign gray_err_o = gray_err_reg;
`else
    assign gray_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_r2w_flags.sv
// Directed bench for sync_r2w_flags with AWIDTH=3, SYNC_STAGES=3, AF_LEVEL=7.
module tb_sync_r2w_flags;

    logic       wr_clk_i = 1'b0;
    logic       aclr_i;
    logic [3:0] wr_pntr_next_i;
    logic [3:0] rd_pntr_gray_wr_i;
    logic       rd_empty_wr_i;
    logic [3:0] rd_pntr_gray_o;
    logic [3:0] rd_pntr_bin_o;
    logic       wr_empty_o;
    logic [3:0] wr_usedw_o;
    logic       wr_full_o;
    logic       wr_almost_full_o;
    logic       gray_err_o;

    int vectors    = 0;
    int miscompares = 0;
    logic exp_err;

    sync_r2w_flags #(.AWIDTH(3), .SYNC_STAGES(3), .AF_LEVEL(7)) dut (
        .wr_clk_i          (wr_clk_i),
        .aclr_i            (aclr_i),
        .wr_pntr_next_i    (wr_pntr_next_i),
        .rd_pntr_gray_wr_i (rd_pntr_gray_wr_i),
        .rd_empty_wr_i     (rd_empty_wr_i),
        .rd_pntr_gray_o    (rd_pntr_gray_o),
        .rd_pntr_bin_o     (rd_pntr_bin_o),
        .wr_empty_o        (wr_empty_o),
        .wr_usedw_o        (wr_usedw_o),
        .wr_full_o         (wr_full_o),
        .wr_almost_full_o  (wr_almost_full_o),
        .gray_err_o        (gray_err_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("t=%0t %s obs=%0h exp=%0h", $time, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge wr_clk_i);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gray"},  32'(rd_pntr_gray_o),   32'h0);
        check({tag, "_bin"},   32'(rd_pntr_bin_o),    32'h0);
        check({tag, "_empty"}, 32'(wr_empty_o),       32'h1);
        check({tag, "_usedw"}, 32'(wr_usedw_o),       32'h0);
        check({tag, "_full"},  32'(wr_full_o),        32'h0);
        check({tag, "_af"},    32'(wr_almost_full_o), 32'h0);
        check({tag, "_err"},   32'(gray_err_o),       32'h0);
    endtask

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
`ifdef SYNC_R2W_GRAY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        aclr_i = 1'b1;
        wr_pntr_next_i = 4'd0;
        rd_pntr_gray_wr_i = 4'd0;
        rd_empty_wr_i = 1'b1;
        #2;
        check_reset_state("por");
        tick();
        check_reset_state("por_hold");
        aclr_i = 1'b0;

        // Latency: one write committed and read pointer 0->1 launched together
        wr_pntr_next_i = 4'd1;
        rd_pntr_gray_wr_i = 4'd1;
        tick();
        check("lat_e1_usedw", 32'(wr_usedw_o), 32'd1);
        check("lat_e1_gray", 32'(rd_pntr_gray_o), 32'd0);
        tick();
        check("lat_e2_gray", 32'(rd_pntr_gray_o), 32'd0);
        tick();
        check("lat_e3_gray", 32'(rd_pntr_gray_o), 32'd1);
        check("lat_e3_bin", 32'(rd_pntr_bin_o), 32'd0);
        check("lat_e3_usedw", 32'(wr_usedw_o), 32'd1);
        tick();
        check("lat_e4_bin", 32'(rd_pntr_bin_o), 32'd1);
        check("lat_e4_usedw", 32'(wr_usedw_o), 32'd0);

        // Fill with read pointer at 1: usedw = wr - 1, almost-full from 7, full at 8
        for (int w = 2; w <= 9; w++) begin
            wr_pntr_next_i = 4'(w);
            tick();
            check($sformatf("fill_usedw_%0d", w-1), 32'(wr_usedw_o), 32'(w-1));
            check($sformatf("fill_af_%0d", w-1), 32'(wr_almost_full_o), 32'((w-1) >= 7));
            check($sformatf("fill_full_%0d", w-1), 32'(wr_full_o), 32'((w-1) == 8));
        end

        // Wrap: write pointer wraps to 0b0001, read walks one Gray step per edge up to 9
        wr_pntr_next_i = 4'b0001;
        for (int r = 2; r <= 9; r++) begin
            rd_pntr_gray_wr_i = to_gray(r);
            tick();
        end
        tick(); tick(); tick(); tick();
        check("wrap_gray", 32'(rd_pntr_gray_o), 32'hD);
        check("wrap_bin", 32'(rd_pntr_bin_o), 32'd9);
        check("wrap_usedw", 32'(wr_usedw_o), 32'd8);
        check("wrap_full", 32'(wr_full_o), 32'd1);
        rd_pntr_gray_wr_i = to_gray(10);
        tick(); tick(); tick();
        check("wrap_rd10_e3_full", 32'(wr_full_o), 32'd1);
        check("wrap_rd10_e3_gray", 32'(rd_pntr_gray_o), 32'hF);
        tick();
        check("wrap_rd10_e4_usedw", 32'(wr_usedw_o), 32'd7);
        check("wrap_rd10_e4_full", 32'(wr_full_o), 32'd0);
        check("wrap_rd10_e4_af", 32'(wr_almost_full_o), 32'd1);

        // Empty flag crossing 1 -> 0 -> 1
        rd_empty_wr_i = 1'b0;
        tick(); tick();
        check("empty_fall_e2", 32'(wr_empty_o), 32'd1);
        tick();
        check("empty_fall_e3", 32'(wr_empty_o), 32'd0);
        rd_empty_wr_i = 1'b1;
        tick(); tick();
        check("empty_rise_e2", 32'(wr_empty_o), 32'd0);
        tick();
        check("empty_rise_e3", 32'(wr_empty_o), 32'd1);
        check("err_clean_traffic", 32'(gray_err_o), 32'd0);

        // Asynchronous reset mid-cycle, away from any clock edge
        rd_pntr_gray_wr_i = 4'd0;
        wr_pntr_next_i = 4'd3;
        rd_empty_wr_i = 1'b0;
        #2;
        aclr_i = 1'b1;
        #1;
        check_reset_state("mid_rst");
        wr_pntr_next_i = 4'd0;
        rd_empty_wr_i = 1'b1;
        tick();
        aclr_i = 1'b0;

        // Gray checker: 0b0000 -> 0b0011 is a two-bit jump
        rd_pntr_gray_wr_i = 4'b0011;
        tick(); tick(); tick();
        check("chk_e3_gray", 32'(rd_pntr_gray_o), 32'h3);
        check("chk_e3_err", 32'(gray_err_o), 32'd0);
        tick();
        check("chk_e4_err", 32'(gray_err_o), 32'(exp_err));
        tick(); tick(); tick();
        check("chk_sticky_err", 32'(gray_err_o), 32'(exp_err));
        #2;
        aclr_i = 1'b1;
        #1;
        check("chk_rst_err", 32'(gray_err_o), 32'd0);
        check("chk_rst_gray", 32'(rd_pntr_gray_o), 32'd0);
        tick();
        aclr_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
